// File: rtl/nv_ram_rwsp_8x129_fifo_rd.sv
// Valid/ready FIFO controller for an external 8x129 rwsp RAM with a two-cycle registered read.
// Optional occupancy output fifo_lvl is enabled by defining NV_RAM_FIFO_LVL_EN.
module nv_ram_rwsp_8x129_fifo_rd #(
    parameter int DW = 129,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd
`ifdef NV_RAM_FIFO_LVL_EN
    ,
    output logic [AW:0]   fifo_lvl
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(1 << AW);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic          s1_vld;
    logic          s2_vld;
    logic          s1_vld_nxt;
    logic          s2_vld_nxt;
    logic          wr_accept;
    logic          pop;
    logic          s1_adv;
    logic          s2_adv;

    // The power bus is wired to the RAM by the parent; it only passes through this level.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_comb begin
        wr_prdy     = (ram_cnt != FULL_CNT);
        wr_accept   = wr_pvld & wr_prdy;
        pop         = s2_vld & rd_prdy;
        s2_adv      = s1_vld & (~s2_vld | pop);
        // An entry already captured in s1 is still counted in ram_cnt, so it must be excluded.
        s1_adv      = (ram_cnt > {{AW{1'b0}}, s1_vld}) & (~s1_vld | s2_adv);
        ram_cnt_nxt = ram_cnt + (AW+1)'(wr_accept) - (AW+1)'(s2_adv);
        s1_vld_nxt  = s1_adv | (s1_vld & ~s2_adv);
        s2_vld_nxt  = s2_adv | (s2_vld & ~pop);
    end

    assign ram_we  = wr_accept;
    assign ram_wa  = wr_ptr;
    assign ram_di  = wr_pd;
    assign ram_ra  = rd_ptr;
    assign ram_re  = s1_adv;
    assign ram_ore = s2_adv;
    assign rd_pvld = s2_vld;
    assign rd_pd   = ram_dout;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
    // the RAM array itself lives outside and is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (s1_adv)    rd_ptr <= rd_ptr + 1'b1;
            ram_cnt <= ram_cnt_nxt;
            s1_vld  <= s1_vld_nxt;
            s2_vld  <= s2_vld_nxt;
        end
    end

`ifdef NV_RAM_FIFO_LVL_EN
    // Registered from next-state values so it tracks ram_cnt + s2_vld without lag.
    always_ff @(posedge clk) begin
        if (reset) fifo_lvl <= '0;
        else       fifo_lvl <= ram_cnt_nxt + (AW+1)'(s2_vld_nxt);
    end
`endif

endmodule
